// File: rtl/audio_out_pkg.sv
// audio_out_pkg
// Shared constants and helpers for the multi-channel delta-sigma audio output
// stage (audio_dsm_out and its per-channel modulator audio_dsm_channel).
//   DEFAULT_RATE_DIV : clk cycles per sample period (50 MHz / 48 kHz)
//   LFSR_SEED        : reset value of the dither LFSR
//   LFSR_TAPS        : feedback mask for taps 16,14,13,11 (bit 15 = tap 16)
//   to_offset()      : signed two's complement -> offset binary (MSB invert)
package audio_out_pkg;

    localparam int          DEFAULT_RATE_DIV = 1042;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;

    // Works on samples up to 32 bits wide; callers truncate the result back
    // to their own width.
    function automatic logic [31:0] to_offset(input logic [31:0] sample,
                                              input int          width);
        to_offset = sample ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/audio_dsm_channel.sv
// audio_dsm_channel
// One first-order delta-sigma modulator. Each clk cycle the offset-binary
// sample is added to a WIDTH-bit accumulator; the carry out is the output bit.
// Optional dither (macro AUDIO_DSM_DITHER_EN) adds a signed nibble (-8..7) to
// the offset-binary sample and saturates to [0, 2^WIDTH-1].
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   sample     : current PCM sample, signed two's complement
//   dither     : raw LFSR nibble (only present with AUDIO_DSM_DITHER_EN)
//   bit_out    : registered bitstream output
module audio_dsm_channel
    import audio_out_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
`ifdef AUDIO_DSM_DITHER_EN
    input  logic [3:0]       dither,
`endif
    output logic             bit_out
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             bit_q, bit_d;
    logic [WIDTH-1:0] u_raw;
    logic [WIDTH-1:0] u;
    logic [WIDTH:0]   sum;
`ifdef AUDIO_DSM_DITHER_EN
    logic signed [4:0]       dither_s;
    logic signed [WIDTH+1:0] dithered;
`endif

    always_comb begin
        u_raw = WIDTH'(to_offset(32'(sample), WIDTH));
`ifdef AUDIO_DSM_DITHER_EN
        dither_s = $signed({1'b0, dither}) - 5'sd8;
        dithered = $signed({2'b00, u_raw})
                 + $signed({{(WIDTH-3){dither_s[4]}}, dither_s});
        // Top bit set means negative; bit WIDTH set means above full scale.
        if (dithered[WIDTH+1]) begin
            u = '0;
        end else if (dithered[WIDTH]) begin
            u = '1;
        end else begin
            u = dithered[WIDTH-1:0];
        end
`else
        u = u_raw;
`endif
        sum   = {1'b0, acc_q} + {1'b0, u};
        acc_d = sum[WIDTH-1:0];
        bit_d = sum[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/audio_dsm_out.sv
// audio_dsm_out
// Multi-channel 1-bit audio output stage. PCM frames (all channels in one
// word, channel 0 in the LSBs) are pushed over valid/ready into a frame FIFO.
// A rate divider pops one frame per sample period into the current-sample
// registers, which feed one delta-sigma modulator per channel at clk rate.
// An empty FIFO at a sample tick repeats the last sample and sets a sticky
// underrun flag. Optional macro AUDIO_DSM_DITHER_EN adds shared LFSR dither.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : runs the sample-rate divider (0 clears it, no pops)
//   in_data/in_valid: frame input; in_ready = FIFO not full
//   clear_underrun  : clears underrun (a coincident set wins)
//   underrun        : sticky, FIFO was empty at a sample tick
//   fifo_level      : frames currently stored
//   audio_out       : registered bitstreams, bit n = channel n
module audio_dsm_out
    import audio_out_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RATE_DIV   = DEFAULT_RATE_DIV
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        clear_underrun,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CHANNELS-1:0]         audio_out
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               CNT_W      = $clog2(RATE_DIV);
    localparam int               FRAME_W    = CHANNELS * WIDTH;
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RATE_DIV - 1);

    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underrun_q, underrun_d;
    logic [FRAME_W-1:0] cur_sample_q, cur_sample_d;
    logic               push, pop, tick, empty;
`ifdef AUDIO_DSM_DITHER_EN
    logic [15:0]        lfsr_q, lfsr_d;
`endif

    // in_ready comes straight from the level register, so it never depends
    // combinationally on in_valid.
    assign in_ready = (level_q != LEVEL_FULL);

    always_comb begin
        empty = (level_q == '0);
        push  = in_valid && in_ready;
        tick  = enable && (cnt_q == CNT_LAST);
        pop   = tick && !empty;

        if (!enable || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end

        // Depth is a power of two, so the pointers wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        cur_sample_d = pop ? mem_q[rd_ptr_q] : cur_sample_q;

        if (tick && empty) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

`ifdef AUDIO_DSM_DITHER_EN
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            underrun_q   <= 1'b0;
            cur_sample_q <= '0;
`ifdef AUDIO_DSM_DITHER_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            cur_sample_q <= cur_sample_d;
`ifdef AUDIO_DSM_DITHER_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    // Frame storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign underrun   = underrun_q;
    assign fifo_level = level_q;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        audio_dsm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .sample  (cur_sample_q[n*WIDTH +: WIDTH]),
`ifdef AUDIO_DSM_DITHER_EN
            .dither  (lfsr_q[(4*n)%16 +: 4]),
`endif
            .bit_out (audio_out[n])
        );
    end

endmodule

// File: tb/tb_audio_dsm_out.sv
// tb_audio_dsm_out
// Directed bench for audio_dsm_out (CHANNELS=2, WIDTH=16, FIFO_DEPTH=16,
// RATE_DIV=16). Accepted frames are queued as expected samples; a monitor
// compares each popped frame against the queue once it loads.
module tb_audio_dsm_out;

    localparam int CHANNELS   = 2;
    localparam int WIDTH      = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int RATE_DIV   = 16;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        enable;
    logic [CHANNELS*WIDTH-1:0]   in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        clear_underrun;
    logic                        underrun;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [CHANNELS-1:0]         audio_out;

    int   nChecks = 0;
    int   nFails  = 0;
    logic [31:0] expQ[$];
    bit   popPending = 0;

    audio_dsm_out #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RATE_DIV   (RATE_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .clear_underrun (clear_underrun),
        .underrun       (underrun),
        .fifo_level     (fifo_level),
        .audio_out      (audio_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one frame for one cycle; an accepted frame becomes an expected pop.
    task automatic applyStimulus(input logic [31:0] frame, output bit accepted);
        in_data  = frame;
        in_valid = 1'b1;
        accepted = in_ready;
        if (accepted) expQ.push_back(frame);
        stepCycles(1);
        in_valid = 1'b0;
    endtask

    // A pop in cycle T loads the current samples at the edge ending T,
    // so the comparison lands on the following falling edge.
    initial begin : monitor
        logic [31:0] expFrame;
        forever begin
            @(negedge clk);
            if (popPending) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected pop: got %0h, expected no pop", dut.cur_sample_q);
                end else begin
                    expFrame = expQ.pop_front();
                    checkOutput("popped frame", dut.cur_sample_q, expFrame);
                end
            end
            popPending = dut.pop && !reset;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit acc;
        int ones0, ones1, toggles0, toggles1;
        logic prev0, prev1;

        reset = 1'b1; enable = 1'b0; in_data = '0; in_valid = 1'b0; clear_underrun = 1'b0;
        stepCycles(3);
        checkOutput("reset level", fifo_level, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset underrun", underrun, 0);
        checkOutput("reset audio_out", audio_out, 0);
        checkOutput("reset sample", dut.cur_sample_q, 0);
        reset = 1'b0;

        // Zero frame: offset 0x8000 on both channels -> 0,1,0,1 bitstream.
        $display("[TB] zero frame");
        applyStimulus(32'h0000_0000, acc);
        checkOutput("level after push", fifo_level, 1);
        enable = 1'b1;
        stepCycles(RATE_DIV);
        enable = 1'b0;
        checkOutput("level after pop", fifo_level, 0);
        stepCycles(2);
        ones0 = 0; toggles0 = 0; toggles1 = 0;
        prev0 = audio_out[0]; prev1 = audio_out[1];
        for (int i = 0; i < 32; i++) begin
            stepCycles(1);
            if (audio_out[0] != prev0) toggles0++;
            if (audio_out[1] != prev1) toggles1++;
            ones0 += int'(audio_out[0]);
            prev0 = audio_out[0]; prev1 = audio_out[1];
        end
        checkOutput("ch0 toggles", toggles0, 32);
        checkOutput("ch1 toggles", toggles1, 32);
        checkOutput("ch0 ones of 32", ones0, 16);

        // Full-scale extremes: ch0 = -32768 -> never 1, ch1 = +32767 -> 65535/65536.
        $display("[TB] full-scale density");
        applyStimulus(32'h7FFF_8000, acc);
        enable = 1'b1;
        stepCycles(RATE_DIV);
        enable = 1'b0;
        stepCycles(2);
        ones0 = 0; ones1 = 0;
        for (int i = 0; i < 65536; i++) begin
            stepCycles(1);
            ones0 += int'(audio_out[0]);
            ones1 += int'(audio_out[1]);
        end
        checkOutput("ch0 density", ones0, 0);
        checkOutput("ch1 density", ones1, 65535);

        // Fill the FIFO with the divider stopped, then overfill by one.
        $display("[TB] fill FIFO");
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            applyStimulus({16'hA000 + 16'(i), 16'(i) << 8}, acc);
        end
        checkOutput("full in_ready", in_ready, 0);
        checkOutput("full level", fifo_level, 16);
        applyStimulus(32'hDEAD_BEEF, acc);
        checkOutput("17th accepted", acc, 0);
        checkOutput("level after 17th", fifo_level, 16);
        enable = 1'b1;
        stepCycles(RATE_DIV);
        enable = 1'b0;
        checkOutput("level after full pop", fifo_level, 15);
        checkOutput("in_ready after full pop", in_ready, 1);

        // Drain the remaining 15 frames, then hit empty ticks.
        $display("[TB] drain and underrun");
        enable = 1'b1;
        stepCycles(15 * RATE_DIV);
        checkOutput("drained level", fifo_level, 0);
        checkOutput("underrun before empty tick", underrun, 0);
        stepCycles(RATE_DIV - 1);
        checkOutput("underrun at empty tick", underrun, 0);
        stepCycles(1);
        checkOutput("underrun after empty tick", underrun, 1);
        checkOutput("held sample", dut.cur_sample_q, 32'hA00F_0F00);
        stepCycles(RATE_DIV - 1);
        clear_underrun = 1'b1;
        stepCycles(1);
        clear_underrun = 1'b0;
        enable = 1'b0;
        checkOutput("set beats clear", underrun, 1);
        clear_underrun = 1'b1;
        stepCycles(1);
        clear_underrun = 1'b0;
        checkOutput("underrun cleared", underrun, 0);

        // Steady stream: one push per period, landing on the tick cycle.
        $display("[TB] steady stream");
        applyStimulus(32'h0100_1000, acc);
        checkOutput("stream level start", fifo_level, 1);
        enable = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            stepCycles(RATE_DIV - 1);
            applyStimulus({16'(k) << 8, 16'(k) << 12}, acc);
            checkOutput("stream level", fifo_level, 1);
        end
        enable = 1'b0;
        stepCycles(1);

        // Reset with 5 frames buffered discards them.
        $display("[TB] reset with frames buffered");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0500_5000 + 32'(i), acc);
        end
        checkOutput("buffered level", fifo_level, 5);
        reset = 1'b1;
        expQ.delete();
        stepCycles(1);
        checkOutput("mid reset level", fifo_level, 0);
        checkOutput("mid reset in_ready", in_ready, 1);
        checkOutput("mid reset underrun", underrun, 0);
        checkOutput("mid reset audio_out", audio_out, 0);
        checkOutput("mid reset sample", dut.cur_sample_q, 0);
        reset = 1'b0;
        stepCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/audio_dsm_out.md
Name: audio_dsm_out

Overview:
- Parametrised multi-channel 1-bit audio output stage.
- Accepts PCM frames (all channels in one word) over a valid/ready handshake and buffers them in a frame FIFO.
- Pops one frame per sample period from an internal rate divider.
- Drives one first-order delta-sigma bitstream per channel, running at the system clock. Successor to the fixed stereo output path: arbitrary channel count and width, buffering, underrun reporting, one clock domain.

Parameters:
- CHANNELS, 2, number of output channels.
- WIDTH, 16, PCM sample width; signed two's complement.
- FIFO_DEPTH, 16, frame FIFO depth; power of two, >=2.
- RATE_DIV, 1042, clk cycles per sample period (50 MHz / 48 kHz); >=4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample-rate divider run.
- in_data  in  CHANNELS*WIDTH  frame; channel 0 in the LSBs.
- in_valid  in  1  frame valid.
- in_ready  out  1  FIFO not full.
- clear_underrun  in  1  clears the underrun flag.
- underrun  out  1  sticky; FIFO was empty at a sample tick.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- audio_out  out  CHANNELS  registered delta-sigma bitstreams, bit n = channel n.

Behaviour:
- Reset values (synchronous, active-high): FIFO empty, fifo_level=0, in_ready=1, rate counter=0, underrun=0, current samples=0 (signed zero), accumulators=0, audio_out=0. Reset asserted mid-frame discards all buffered frames.
- Push: on in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH). No combinational path from in_valid to in_ready.
- Rate counter:
  - Counts 0..RATE_DIV-1 while enable=1. tick = (count==RATE_DIV-1 && enable). Wraps to 0.
  - enable=0 clears the counter to 0 and suppresses pops. Modulators keep running on the held sample.
- At tick, FIFO non-empty: pop one frame; current samples load at T+1.
- At tick, FIFO empty: no pop, current samples held (last value repeats), underrun set at T+1.
- underrun set and clear_underrun in the same cycle: set wins.
- Push and pop in the same cycle: level unchanged. Full plus tick: pop proceeds; in_ready rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Per-channel modulator, every clk cycle:
  - u = sample with MSB inverted (offset binary, 0..2^WIDTH-1).
  - sum = {1'b0,acc} + u, WIDTH+1 bits.
  - acc <= sum[WIDTH-1:0]; audio_out[n] <= sum[WIDTH].
- Latency: pop at T -> new u used at T+1 -> first bitstream bit from new sample visible at T+2.
- Density: ones density of audio_out[n] = u/2^WIDTH exactly over 2^WIDTH cycles for a constant sample.

Optional Feature:
- Macro: AUDIO_DSM_DITHER_EN.
- Defined:
  - Shared 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset), advancing every clk.
  - Each channel n adds signed (lfsr[4n+3:4n] - 8), with LFSR bits indexed modulo 16, to u before accumulation.
  - The result saturates to [0, 2^WIDTH-1].
- Not defined: no LFSR; bit-exact behaviour as above.

Decomposition:
- Package audio_out_pkg:
  - Constant DEFAULT_RATE_DIV.
  - Constants LFSR_SEED and LFSR_TAPS.
  - Function to_offset(sample), which performs the MSB inversion.
- Sub-module audio_dsm_channel (one modulator plus optional dither add), instantiated CHANNELS times in a generate loop.
- FIFO and rate counter stay inline in the top.

Test Plan:
- Reset, then push frame {ch1=16'h0000, ch0=16'h0000}, enable=1 → after the tick, audio_out[0] pattern 0,1,0,1,... from T+2; level returns 0.
- Push ch0=16'h8000, ch1=16'h7FFF → ch0 constantly 0; ch1 exactly 65535 ones per 65536 cycles.
- Push 16 frames with enable=0 → in_ready=0, fifo_level=16, 17th frame not accepted; pulse enable for one tick → level 15, in_ready=1 the next cycle.
- Let FIFO drain → underrun=1 one cycle after the first empty tick, last sample repeated; clear_underrun coincident with another empty tick → underrun stays 1.
- Continuous push with one frame every RATE_DIV cycles, including a push on the tick cycle → level stays constant; frames emitted in order (check sample sequence 0x1000, 0x2000, 0x3000).
- Reset asserted with 5 frames buffered → next cycle level=0, audio_out=0, underrun=0, current sample reads as signed zero.
